// File: rtl/pulse_width_decoder.sv
// Pulse-width decoder: window check, signal-loss supervision, lock FSM, offset-corrected output.
// Optional build macro PULSE_DECODER_FAILSAFE_EN loads K_FAILSAFE_VALUE into o_value on signal loss.
module pulse_width_decoder #(
    parameter int K_CNTWIDTH       = 16,
    parameter int K_LOCK_CNT       = 3,
    parameter int K_FAILSAFE_VALUE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rise,
    input  logic                  i_fall,
    input  logic                  i_elapsed,
    input  logic [K_CNTWIDTH-1:0] i_cnt,
    input  logic [K_CNTWIDTH-1:0] i_min_width,
    input  logic [K_CNTWIDTH-1:0] i_max_width,
    input  logic [K_CNTWIDTH-1:0] i_timeout,
    output logic [K_CNTWIDTH-1:0] o_value,
    output logic                  o_valid,
    output logic                  o_locked,
    output logic                  o_nosig,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        ST_NOSIG = 2'd0,
        ST_ACQ   = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [3:0]            LOCK_CNT_C = 4'(K_LOCK_CNT);
    localparam logic [K_CNTWIDTH-1:0] CNT_MAX_C  = {K_CNTWIDTH{1'b1}};
    localparam logic [K_CNTWIDTH-1:0] CNT_ZERO_C = {K_CNTWIDTH{1'b0}};
`ifdef PULSE_DECODER_FAILSAFE_EN
    localparam logic [K_CNTWIDTH-1:0] FAILSAFE_C = K_CNTWIDTH'(K_FAILSAFE_VALUE);
`endif

    state_t                  state_r, state_s;
    logic [3:0]              good_cnt_r, good_cnt_s;
    logic [K_CNTWIDTH-1:0]   period_r, period_s;
    logic [K_CNTWIDTH-1:0]   value_r, value_s;
    logic                    armed_r, armed_s;
    logic                    overlong_r, overlong_s;
    logic                    valid_r, valid_s;
    logic                    err_r, err_s;
    logic                    locked_r, nosig_r;
    logic                    in_window_s, pulse_ok_s, pulse_bad_s, timeout_s;

    // Pulse qualification and signal-loss detection for the current cycle.
    always_comb begin
        in_window_s = (i_cnt >= i_min_width) && (i_cnt <= i_max_width);
        pulse_ok_s  = i_fall && armed_r && !overlong_r && in_window_s;
        pulse_bad_s = i_fall && armed_r && !pulse_ok_s;
        timeout_s   = (i_timeout != CNT_ZERO_C) && (period_r >= i_timeout)
                      && !i_rise && (state_r != ST_NOSIG);
    end

    // Next-state, counters and output strobes.
    always_comb begin
        state_s    = state_r;
        good_cnt_s = good_cnt_r;
        value_s    = value_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;

        if (i_rise) begin
            period_s = CNT_ZERO_C;
        end else if (period_r == CNT_MAX_C) begin
            period_s = period_r;
        end else begin
            period_s = period_r + {{(K_CNTWIDTH-1){1'b0}}, 1'b1};
        end

        if (i_rise) begin
            armed_s = 1'b1;
        end else if (i_fall) begin
            armed_s = 1'b0;
        end else begin
            armed_s = armed_r;
        end

        // elapsed wins over a coincident rise
        if (i_elapsed) begin
            overlong_s = 1'b1;
        end else if (i_rise) begin
            overlong_s = 1'b0;
        end else begin
            overlong_s = overlong_r;
        end

        if (timeout_s) begin
            state_s    = ST_NOSIG;
            good_cnt_s = 4'd0;
            armed_s    = 1'b0;
`ifdef PULSE_DECODER_FAILSAFE_EN
            value_s    = FAILSAFE_C;
            valid_s    = 1'b1;
`else
            value_s    = value_r;
`endif
        end else begin
            case (state_r)
                ST_NOSIG: begin
                    if (i_rise) begin
                        state_s = ST_ACQ;
                    end else begin
                        state_s = ST_NOSIG;
                    end
                end
                ST_ACQ: begin
                    if (pulse_ok_s) begin
                        good_cnt_s = good_cnt_r + 4'd1;
                        if ((good_cnt_r + 4'd1) == LOCK_CNT_C) begin
                            state_s = ST_LOCK;
                            value_s = i_cnt - i_min_width;
                            valid_s = 1'b1;
                        end else begin
                            state_s = ST_ACQ;
                        end
                    end else if (pulse_bad_s) begin
                        good_cnt_s = 4'd0;
                        err_s      = 1'b1;
                    end else begin
                        state_s = ST_ACQ;
                    end
                end
                ST_LOCK: begin
                    if (pulse_ok_s) begin
                        value_s = i_cnt - i_min_width;
                        valid_s = 1'b1;
                    end else if (pulse_bad_s) begin
                        good_cnt_s = 4'd0;
                        err_s      = 1'b1;
                        state_s    = ST_ACQ;
                    end else begin
                        state_s = ST_LOCK;
                    end
                end
                default: begin
                    state_s    = ST_NOSIG;
                    good_cnt_s = 4'd0;
                    armed_s    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_NOSIG;
            good_cnt_r <= 4'd0;
            period_r   <= CNT_ZERO_C;
            value_r    <= CNT_ZERO_C;
            armed_r    <= 1'b0;
            overlong_r <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            locked_r   <= 1'b0;
            nosig_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            good_cnt_r <= good_cnt_s;
            period_r   <= period_s;
            value_r    <= value_s;
            armed_r    <= armed_s;
            overlong_r <= overlong_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            locked_r   <= (state_s == ST_LOCK);
            nosig_r    <= (state_s == ST_NOSIG);
        end
    end

    assign o_value  = value_r;
    assign o_valid  = valid_r;
    assign o_err    = err_r;
    assign o_locked = locked_r;
    assign o_nosig  = nosig_r;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder; expected o_valid/o_err events are queued at drive time.
`timescale 1ns/1ps
module tb_pulse_width_decoder;

    localparam logic [1:0] EV_NONE  = 2'b00;
    localparam logic [1:0] EV_VALID = 2'b10;
    localparam logic [1:0] EV_ERR   = 2'b01;
    localparam logic [15:0] FS_VAL  = 16'h0200;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rise = 1'b0, fall = 1'b0, elapsed = 1'b0;
    logic [15:0] cnt = 16'd0, min_w = 16'd1000, max_w = 16'd2000, tmo = 16'd40000;
    logic [15:0] o_value;
    logic        o_valid, o_locked, o_nosig, o_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    pulse_width_decoder #(
        .K_CNTWIDTH(16), .K_LOCK_CNT(3), .K_FAILSAFE_VALUE(16'h0200)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rise(rise), .i_fall(fall),
        .i_elapsed(elapsed), .i_cnt(cnt), .i_min_width(min_w),
        .i_max_width(max_w), .i_timeout(tmo), .o_value(o_value),
        .o_valid(o_valid), .o_locked(o_locked), .o_nosig(o_nosig), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc + 1;
        if (kind != EV_NONE) sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rise_only();
        @(negedge clk);
        rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
    endtask

    task automatic fall_only(input logic [15:0] w, input logic [1:0] kind, input logic [15:0] val);
        cnt  = w;
        fall = 1'b1;
        push_exp(kind, val);
        @(negedge clk);
        fall = 1'b0;
    endtask

    task automatic send_pulse(input logic [15:0] w, input bit elap,
                              input logic [1:0] kind, input logic [15:0] val);
        idle(200);
        rise_only();
        idle(2);
        if (elap) begin
            elapsed = 1'b1;
            @(negedge clk);
            elapsed = 1'b0;
        end
        fall_only(w, kind, val);
        idle(3);
    endtask

    task automatic relock();
        send_pulse(16'd1500, 1'b0, EV_NONE, 16'd0);
        send_pulse(16'd1500, 1'b0, EV_NONE, 16'd0);
        send_pulse(16'd1500, 1'b0, EV_VALID, 16'd500);
        chk("relock_locked", o_locked, 1);
    endtask

    // Output monitor: every o_valid/o_err must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (o_valid || o_err)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_event", {o_valid, o_err}, EV_NONE);
            end else begin
                mon_e = sb_q.pop_front();
                chk("event_kind", {o_valid, o_err}, mon_e.kind);
                chk("event_cycle", cyc, mon_e.cyc);
                if (o_valid) chk("event_value", o_value, mon_e.val);
            end
        end
    end

    initial begin
        idle(3);
        chk("rst_value", o_value, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_nosig", o_nosig, 1);
        chk("rst_err", o_err, 0);
        rst_n = 1'b1;
        idle(2);

        // Unarmed fall is ignored
        fall_only(16'd1500, EV_NONE, 16'd0);
        idle(2);
        chk("unarmed_nosig", o_nosig, 1);

        // Acquisition
        send_pulse(16'd1500, 1'b0, EV_NONE, 16'd0);
        chk("acq1_locked", o_locked, 0);
        chk("acq1_nosig", o_nosig, 0);
        send_pulse(16'd1500, 1'b0, EV_NONE, 16'd0);
        chk("acq2_locked", o_locked, 0);
        send_pulse(16'd1500, 1'b0, EV_VALID, 16'd500);
        chk("lock_locked", o_locked, 1);
        chk("lock_value", o_value, 500);

        // Window boundaries just outside
        send_pulse(16'd999, 1'b0, EV_ERR, 16'd0);
        chk("w999_locked", o_locked, 0);
        chk("w999_value", o_value, 500);
        relock();
        send_pulse(16'd2001, 1'b0, EV_ERR, 16'd0);
        chk("w2001_locked", o_locked, 0);
        chk("w2001_value", o_value, 500);
        relock();

        // Window boundaries inclusive
        send_pulse(16'd1000, 1'b0, EV_VALID, 16'd0);
        chk("w1000_value", o_value, 0);
        send_pulse(16'd2000, 1'b0, EV_VALID, 16'd1000);
        chk("w2000_value", o_value, 1000);
        chk("w2000_locked", o_locked, 1);

        // Overlong pulse
        send_pulse(16'd1500, 1'b1, EV_ERR, 16'd0);
        chk("elapsed_locked", o_locked, 0);
        chk("elapsed_nosig", o_nosig, 0);
        relock();

        // Timeout exactly at period count == 40000
        rise_only();
        fall_only(16'd1500, EV_VALID, 16'd500);
        idle(40000 - 1);
        chk("tmo_before_nosig", o_nosig, 0);
`ifdef PULSE_DECODER_FAILSAFE_EN
        push_exp(EV_VALID, FS_VAL);
`endif
        idle(1);
        chk("tmo_nosig", o_nosig, 1);
        chk("tmo_locked", o_locked, 0);
`ifdef PULSE_DECODER_FAILSAFE_EN
        chk("tmo_failsafe_value", o_value, FS_VAL);
`else
        chk("tmo_hold_value", o_value, 500);
`endif
        idle(5);

        // Rise on the timeout cycle suppresses it
        relock();
        tmo = 16'd4000;
        rise_only();
        fall_only(16'd1500, EV_VALID, 16'd500);
        idle(4000 - 2);
        rise_only();
        chk("supp_nosig", o_nosig, 0);
        chk("supp_locked", o_locked, 1);
        idle(3);

        // Reset mid-pulse, then a stray fall
        rise_only();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        fall_only(16'd1500, EV_NONE, 16'd0);
        idle(2);
        chk("midrst_nosig", o_nosig, 1);
        chk("midrst_value", o_value, 0);

        // Inverted window rejects everything
        min_w = 16'd2000;
        max_w = 16'd1000;
        send_pulse(16'd1500, 1'b0, EV_ERR, 16'd0);
        chk("inv_locked", o_locked, 0);

        idle(5);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
